stage_scheduler: RTL and testbench

Sequences the guitar effect chain's valid-gated pipeline registers. For each accepted audio sample it walks the chain stage by stage, waits each stage's programmed compute latency, then pulses that stage's register load enable. After the last stage it raises a one-cycle output-valid strobe. It sits between the ADC sample strobe and the effect-stage registers, and reports samples dropped while a sequence is still running.

---
 rtl/stage_sched_pkg.sv | 18 +
 rtl/stage_latency_counter.sv | 41 ++++
 rtl/stage_scheduler.sv | 159 +++++++++++++++
 tb/tb_stage_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_sched_pkg.sv
// stage_sched_pkg
// Shared types and default parameter values for the effect-chain stage
// scheduler and its latency counter.
//   sched_state_t : scheduler FSM state encoding
//   DEF_*         : default parameter values for stage_scheduler
package stage_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int DEF_N_STAGES = 4;
  localparam int DEF_LAT_W    = 8;
  localparam int DEF_DROP_W   = 8;

endpackage

// File: rtl/stage_latency_counter.sv
// stage_latency_counter
// Loadable down-counter used to time each stage's compute latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val this cycle (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : count is zero
module stage_latency_counter #(
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/stage_scheduler.sv
// stage_scheduler
// Walks the effect chain for each accepted audio sample: waits each stage's
// programmed latency, pulses that stage's register load enable, and strobes
// out_valid after the last stage. Samples arriving mid-sequence are dropped
// and counted.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   sample_valid   : new input sample strobe
//   stage_latency  : packed per-stage wait cycles, field k at [k*LAT_W +: LAT_W]
//   bypass_mask    : bit k set -> stage k is timed but not loaded
//   clear_overrun  : clears overrun and drop_count (a same-cycle drop wins)
//   stage_load     : one-hot load enable for the stage registers
//   stage_idx      : stage currently being waited
//   busy           : sequence in progress
//   out_valid      : chain output holds the new sample
//   overrun        : sticky, a sample was dropped
//   drop_count     : saturating dropped-sample count
//
// state | meaning
// IDLE  | no sample in flight
// WAIT  | timing stage stage_idx; loads it when the counter reaches zero
// DONE  | last stage loaded, out_valid high; may accept the next sample
module stage_scheduler
  import stage_sched_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int DROP_W   = DEF_DROP_W,
  localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic [N_STAGES*LAT_W-1:0] stage_latency,
  input  logic [N_STAGES-1:0]       bypass_mask,
  input  logic                      clear_overrun,
  output logic [N_STAGES-1:0]       stage_load,
  output logic [IDX_W-1:0]          stage_idx,
  output logic                      busy,
  output logic                      out_valid,
  output logic                      overrun,
  output logic [DROP_W-1:0]         drop_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  sched_state_t                       state_q, state_d;
  logic [N_STAGES-1:0][LAT_W-1:0]     lat_q, lat_d;
  logic [N_STAGES-1:0]                byp_q, byp_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               overrun_q, overrun_d;
  logic [DROP_W-1:0]                  drop_q, drop_d;

  logic             cnt_load;
  logic [LAT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             drop;

  stage_latency_counter #(
    .LAT_W (LAT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign drop = sample_valid && (state_q == WAIT);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    byp_d    = byp_q;
    idx_d    = idx_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (sample_valid) begin
          // The counter takes stage 0 straight from the input since the
          // snapshot is only being captured this cycle.
          state_d  = WAIT;
          lat_d    = stage_latency;
          byp_d    = bypass_mask;
          idx_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = stage_latency[LAT_W-1:0];
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          cnt_load = 1'b1;
          cnt_val  = lat_q[idx_d];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    drop_d    = drop_q;
    if (clear_overrun) begin
      overrun_d = 1'b0;
      drop_d    = '0;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (clear_overrun) begin
        drop_d = DROP_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      byp_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      byp_q     <= byp_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    stage_load = '0;
    if ((state_q == WAIT) && cnt_zero && !byp_q[idx_q]) begin
      stage_load[idx_q] = 1'b1;
    end
  end

  assign stage_idx  = idx_q;
  assign busy       = (state_q == WAIT);
  assign out_valid  = (state_q == DONE);
  assign overrun    = overrun_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_stage_scheduler.sv
// tb_stage_scheduler
// Directed bench for stage_scheduler (N_STAGES=4, LAT_W=8, DROP_W=8).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_stage_scheduler;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [N*LW-1:0] stage_latency;
  logic [N-1:0]  bypass_mask;
  logic          clear_overrun;
  logic [N-1:0]  stage_load;
  logic [1:0]    stage_idx;
  logic          busy;
  logic          out_valid;
  logic          overrun;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  stage_scheduler #(
    .N_STAGES (N),
    .LAT_W    (LW),
    .DROP_W   (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .stage_latency (stage_latency),
    .bypass_mask   (bypass_mask),
    .clear_overrun (clear_overrun),
    .stage_load    (stage_load),
    .stage_idx     (stage_idx),
    .busy          (busy),
    .out_valid     (out_valid),
    .overrun       (overrun),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s/idle_load", tag), 32'(stage_load), 32'd0);
    chk($sformatf("%s/idle_ov", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s/idle_busy", tag), 32'(busy), 32'd0);
  endtask

  // Accepts a sample in the current cycle (c=0) and checks every following
  // cycle up to and including the out_valid cycle against hand-computed
  // stage fire cycles f0..f3 and out_valid cycle ov_at (relative to accept).
  task automatic run_seq(input string tag, input logic [31:0] lat, input logic [3:0] byp,
                         input int f0, input int f1, input int f2, input int f3,
                         input int ov_at, input logic [31:0] drop_cyc, input int clr_cyc,
                         input int chg_cyc, input logic [31:0] chg_lat);
    int fire[4];
    logic [3:0] exp_load;
    int exp_idx;
    fire = '{f0, f1, f2, f3};
    stage_latency = lat;
    bypass_mask   = byp;
    sample_valid  = 1'b1;
    clear_overrun = 1'b0;
    for (int c = 1; c <= ov_at; c++) begin
      next_cyc();
      sample_valid  = 1'b0;
      clear_overrun = 1'b0;
      exp_load = '0;
      exp_idx  = 0;
      for (int k = 0; k < 4; k++) begin
        if (fire[k] == c && !byp[k]) exp_load[k] = 1'b1;
        if (fire[k] < c) exp_idx++;
      end
      if (exp_idx > 3) exp_idx = 3;
      chk($sformatf("%s/load@%0d", tag, c), 32'(stage_load), 32'(exp_load));
      chk($sformatf("%s/ov@%0d", tag, c), 32'(out_valid), 32'(c == ov_at));
      chk($sformatf("%s/busy@%0d", tag, c), 32'(busy), 32'(c < ov_at));
      if (c < ov_at) chk($sformatf("%s/idx@%0d", tag, c), 32'(stage_idx), 32'(exp_idx));
      if (c < 32 && drop_cyc[c]) sample_valid = 1'b1;
      if (c == clr_cyc) clear_overrun = 1'b1;
      if (c == chg_cyc) begin
        stage_latency = chg_lat;
        bypass_mask   = ~byp;
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    stage_latency = '0;
    bypass_mask   = '0;
    repeat (3) next_cyc();
    chk("rst/load", 32'(stage_load), 32'd0);
    chk("rst/idx", 32'(stage_idx), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/ov", 32'(out_valid), 32'd0);
    chk("rst/overrun", 32'(overrun), 32'd0);
    chk("rst/drops", 32'(drop_count), 32'd0);
    rst = 1'b0;
    next_cyc();

    // all latencies zero: loads on consecutive cycles
    run_seq("lat0", 32'h0000_0000, 4'b0000, 1, 2, 3, 4, 5, 32'd0, -1, -1, 32'd0);
    next_cyc();
    chk_idle("lat0");

    // lat = {3,0,5,1}
    run_seq("mixed", 32'h0105_0003, 4'b0000, 4, 5, 11, 13, 14, 32'd0, -1, -1, 32'd0);
    next_cyc();
    chk_idle("mixed");

    // stages 0 and 2 bypassed, all lat 2
    run_seq("bypass", 32'h0202_0202, 4'b0101, 3, 6, 9, 12, 13, 32'd0, -1, -1, 32'd0);
    next_cyc();
    chk_idle("bypass");
    chk("bypass/overrun", 32'(overrun), 32'd0);

    // three drops during WAIT, timing unchanged
    run_seq("drop3", 32'h0202_0202, 4'b0000, 3, 6, 9, 12, 13,
            (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 7), -1, -1, 32'd0);
    next_cyc();
    chk("drop3/overrun", 32'(overrun), 32'd1);
    chk("drop3/drops", 32'(drop_count), 32'd3);

    // clear coinciding with a fourth drop: the drop wins
    run_seq("clrdrop", 32'h0202_0202, 4'b0000, 3, 6, 9, 12, 13, 32'd1 << 4, 4, -1, 32'd0);
    next_cyc();
    chk("clrdrop/overrun", 32'(overrun), 32'd1);
    chk("clrdrop/drops", 32'(drop_count), 32'd1);

    // plain clear
    clear_overrun = 1'b1;
    next_cyc();
    clear_overrun = 1'b0;
    chk("clear/overrun", 32'(overrun), 32'd0);
    chk("clear/drops", 32'(drop_count), 32'd0);

    // lat = {1,2,0,3}; inputs changed mid-sequence; back-to-back accept in out_valid cycle
    run_seq("b2b_a", 32'h0300_0201, 4'b0000, 2, 5, 6, 10, 11, 32'd0, -1, 3, 32'h0000_0000);
    run_seq("b2b_b", 32'h0000_0000, 4'b0000, 1, 2, 3, 4, 5, 32'd0, -1, -1, 32'd0);
    next_cyc();
    chk_idle("b2b");
    chk("b2b/overrun", 32'(overrun), 32'd0);

    // reset while waiting on stage 2 (lat = {3,0,5,1}); leave overrun set first
    stage_latency = 32'h0105_0003;
    bypass_mask   = 4'b0000;
    sample_valid  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cyc();
      sample_valid = (c == 7);
    end
    chk("rstmid/busy_pre", 32'(busy), 32'd1);
    chk("rstmid/idx_pre", 32'(stage_idx), 32'd2);
    chk("rstmid/overrun_pre", 32'(overrun), 32'd1);
    sample_valid = 1'b0;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk("rstmid/load", 32'(stage_load), 32'd0);
    chk("rstmid/idx", 32'(stage_idx), 32'd0);
    chk("rstmid/busy", 32'(busy), 32'd0);
    chk("rstmid/ov", 32'(out_valid), 32'd0);
    chk("rstmid/overrun", 32'(overrun), 32'd0);
    chk("rstmid/drops", 32'(drop_count), 32'd0);
    for (int c = 0; c < 12; c++) begin
      next_cyc();
      chk_idle($sformatf("rstmid_after%0d", c));
    end
    run_seq("postrst", 32'h0000_0000, 4'b0000, 1, 2, 3, 4, 5, 32'd0, -1, -1, 32'd0);
    next_cyc();
    chk_idle("postrst");

    // 300 drops saturate the counter at 255; lat all 255
    stage_latency = 32'hFFFF_FFFF;
    sample_valid  = 1'b1;
    for (int c = 1; c <= 1025; c++) begin
      next_cyc();
      sample_valid = (c <= 300);
      if (c == 255) chk("sat/drops254", 32'(drop_count), 32'd254);
      if (c == 256) chk("sat/load0", 32'(stage_load), 32'd1);
      if (c == 301) chk("sat/drops255", 32'(drop_count), 32'd255);
      if (c == 1024) chk("sat/ov_early", 32'(out_valid), 32'd0);
      if (c == 1025) chk("sat/ov", 32'(out_valid), 32'd1);
    end
    chk("sat/drops_end", 32'(drop_count), 32'd255);
    chk("sat/overrun", 32'(overrun), 32'd1);
    next_cyc();
    chk_idle("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
